// File: rtl/seq_pkg.sv
// Shared definitions for the round-robin pattern sequencer: phase codes,
// output pattern table and control-state encoding.
package seq_pkg;

    localparam int FRAME_LEN = 5;

    localparam logic [2:0] PH_P0 = 3'b000;
    localparam logic [2:0] PH_P1 = 3'b001;
    localparam logic [2:0] PH_P2 = 3'b010;
    localparam logic [2:0] PH_P3 = 3'b011;
    localparam logic [2:0] PH_P4 = 3'b111;

    // Bit i is the sm_out level while the engine sits in phase Pi.
    localparam logic [FRAME_LEN-1:0] SM_PATTERN = 5'b11001;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_DONE = 2'd2
    } ctrl_e;

    function automatic logic phase_is_legal(input logic [2:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            PH_P0, PH_P1, PH_P2, PH_P3, PH_P4: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] phase_next(input logic [2:0] code);
        logic [2:0] nxt;
        nxt = PH_P0;
        case (code)
            PH_P0:   nxt = PH_P1;
            PH_P1:   nxt = PH_P2;
            PH_P2:   nxt = PH_P3;
            PH_P3:   nxt = PH_P4;
            default: nxt = PH_P0;
        endcase
        return nxt;
    endfunction

    // Illegal codes drive the line low until the frame restarts.
    function automatic logic phase_sm(input logic [2:0] code);
        logic lvl;
        lvl = 1'b0;
        case (code)
            PH_P0:   lvl = SM_PATTERN[0];
            PH_P1:   lvl = SM_PATTERN[1];
            PH_P2:   lvl = SM_PATTERN[2];
            PH_P3:   lvl = SM_PATTERN[3];
            PH_P4:   lvl = SM_PATTERN[4];
            default: lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/seq_pattern_core.sv
// Five-phase pattern engine: phase register, sm_out decode and recovery
// from illegal phase codes. Outputs decode only registered state.
module seq_pattern_core
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic sm_out,
    output logic frame_start,
    output logic last_phase,
    output logic err
);

    logic [2:0] phase_q;
    logic [2:0] phase_d;

    // A corrupted code always lands back on P0, whether running or idle.
    always_comb begin
        phase_d = phase_q;
        if (!phase_is_legal(phase_q)) begin
            phase_d = PH_P0;
        end else if (restart) begin
            phase_d = PH_P0;
        end else if (run) begin
            phase_d = phase_next(phase_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= PH_P0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        sm_out      = run & phase_sm(phase_q);
        frame_start = run & (phase_q == PH_P0);
        last_phase  = run & (phase_q == PH_P4);
        err         = ~phase_is_legal(phase_q);
    end

endmodule

// File: rtl/seq_arb_ctrl.sv
// Round-robin arbiter that lends one pattern engine to NREQ requesters,
// one burst of programmed frames at a time.
module seq_arb_ctrl
    import seq_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  frame_start,
    output logic                  sm_out,
    output logic                  done,
    output logic                  aborted,
    output logic                  err
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int IW    = PTR_W + 1;

    ctrl_e            state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             abort_pend_q, abort_pend_d;
    logic             aborted_q, aborted_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [LEN_W-1:0] win_len;
    logic             run;
    logic             restart;
    logic             last_phase;
    logic             owner_drop;

    // Scan upward from rr_ptr, wrapping at NREQ; first set request wins.
    always_comb begin
        logic [IW-1:0]    idx;
        logic [PTR_W-1:0] cand;
        idx       = '0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + IW'(i);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            cand = idx[PTR_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_len = len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign run        = (state_q == CTRL_RUN);
    assign restart    = ~run;
    assign owner_drop = ~|(req & grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        case (state_q)
            CTRL_IDLE: begin
                abort_pend_d = 1'b0;
                aborted_d    = 1'b0;
                if (win_found) begin
                    grant_d     = NREQ'(1) << win_idx;
                    rr_ptr_d    = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    frame_cnt_d = win_len;
                    state_d     = (win_len == '0) ? CTRL_DONE : CTRL_RUN;
                end
            end
            CTRL_RUN: begin
                if (owner_drop) begin
                    abort_pend_d = 1'b1;
                end
                // A dropped request only takes effect once the current frame has finished.
                if (last_phase) begin
                    frame_cnt_d = frame_cnt_q - LEN_W'(1);
                    if (frame_cnt_q == LEN_W'(1) || abort_pend_q || owner_drop) begin
                        state_d   = CTRL_DONE;
                        grant_d   = '0;
                        aborted_d = abort_pend_q | owner_drop;
                    end
                end
            end
            CTRL_DONE: begin
                state_d   = CTRL_IDLE;
                grant_d   = '0;
                aborted_d = 1'b0;
            end
            default: begin
                state_d = CTRL_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= CTRL_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_cnt_q <= frame_cnt_d;
    end

    seq_pattern_core u_core (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .restart     (restart),
        .sm_out      (sm_out),
        .frame_start (frame_start),
        .last_phase  (last_phase),
        .err         (err)
    );

    assign grant   = grant_q;
    assign busy    = run;
    assign done    = (state_q == CTRL_DONE);
    assign aborted = aborted_q;

endmodule

// File: tb/tb_seq_arb_ctrl.sv
// Scoreboard bench for seq_arb_ctrl: expected per-cycle outputs are queued
// with each stimulus and compared on every falling clock edge.
module tb_seq_arb_ctrl;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ-1:0]       grant;
    logic                  busy, frame_start, sm_out, done, aborted, err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        string      tag;
        logic [9:0] vec;
        logic       xsm;
    } exp_t;

    exp_t exp_q[$];
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    seq_arb_ctrl #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .len         (len),
        .grant       (grant),
        .busy        (busy),
        .frame_start (frame_start),
        .sm_out      (sm_out),
        .done        (done),
        .aborted     (aborted),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_rec(input string tag, input logic [3:0] g, input logic b, input logic fs,
                            input logic sm, input logic d, input logic ab, input logic e,
                            input logic xsm);
        exp_t r;
        r.tag = tag;
        r.vec = {g, b, fs, sm, d, ab, e};
        r.xsm = xsm;
        exp_q.push_back(r);
    endtask

    task automatic push_frames(input string tag, input logic [3:0] g, input int n);
        for (int k = 0; k < n; k++) begin
            push_rec(tag, g, 1'b1, (k % 5) == 0, pat[k % 5], 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic push_done(input string tag, input logic [3:0] g, input logic ab);
        push_rec(tag, g, 1'b0, 1'b0, 1'b0, 1'b1, ab, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            push_rec(tag, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // vec layout: {grant[3:0], busy, frame_start, sm_out, done, aborted, err}
    task automatic tick();
        exp_t       r;
        logic [9:0] act;
        logic [9:0] m;
        @(negedge clk);
        cyc++;
        act = {grant, busy, frame_start, sm_out, done, aborted, err};
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            m = r.xsm ? 10'b11_1111_0111 : 10'b11_1111_1111;
            chk($sformatf("%s@%0d", r.tag, cyc), 32'(act & m), 32'(r.vec & m));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        len   = '0;
        repeat (2) @(posedge clk);
        push_idle("reset", 2);
        run(2);
        reset = 1'b1;
        push_idle("idle", 2);
        run(2);

        // Two-frame burst for requester 0.
        len = 16'h0002;
        req = 4'b0001;
        push_frames("t1_pat", 4'b0001, 10);
        push_done("t1_done", 4'b0000, 1'b0);
        run(11);
        req = 4'b0000;
        push_idle("t1_idle", 2);
        run(2);

        // Reset mid-burst: outputs clear, no done, pointer back to 0.
        len = 16'h0030;
        req = 4'b0010;
        push_frames("t6_pat", 4'b0010, 7);
        run(7);
        reset = 1'b0;
        req   = 4'b0000;
        push_idle("t6_rst", 1);
        run(1);
        reset = 1'b1;
        push_idle("t6_nodone", 3);
        run(3);

        // Two requesters held: rotation 0, 2, 0 with a two-cycle gap.
        len = 16'h1111;
        req = 4'b0101;
        push_frames("t2_a", 4'b0001, 5);
        push_done("t2_a_done", 4'b0000, 1'b0);
        push_idle("t2_gap_a", 1);
        push_frames("t2_b", 4'b0100, 5);
        push_done("t2_b_done", 4'b0000, 1'b0);
        push_idle("t2_gap_b", 1);
        push_frames("t2_c", 4'b0001, 5);
        push_done("t2_c_done", 4'b0000, 1'b0);
        run(20);
        req = 4'b0000;
        push_idle("t2_idle", 2);
        run(2);

        // Zero-length burst.
        len = 16'h0000;
        req = 4'b0010;
        push_done("t3_zero", 4'b0010, 1'b0);
        run(1);
        req = 4'b0000;
        push_idle("t3_idle", 3);
        run(3);

        // Abort: request drops at P2 of the second frame.
        len = 16'h0003;
        req = 4'b0001;
        push_frames("t4_pat", 4'b0001, 10);
        push_done("t4_abort", 4'b0000, 1'b1);
        run(8);
        req = 4'b0000;
        run(3);
        push_idle("t4_idle", 2);
        run(2);

        // Illegal phase code injected where P3 would be.
        len = 16'h0002;
        req = 4'b0001;
        push_frames("t5_pre", 4'b0001, 3);
        run(3);
        @(posedge clk);
        #1;
        force dut.u_core.phase_q = 3'b101;
        #2;
        release dut.u_core.phase_q;
        push_rec("t5_err", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run(1);
        push_frames("t5_restart", 4'b0001, 10);
        push_done("t5_done", 4'b0000, 1'b0);
        run(11);
        req = 4'b0000;
        push_idle("t5_idle", 2);
        run(2);

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
